game_sequencer: RTL and testbench

- Top-level game controller that sequences the play session and drives the obstacle generator's `presente`, `W_or_L` and `mundo` inputs.
- Owns the state machine OFF -> WLCM -> CH -> GAME <-> PA -> WL.
- Tracks lives, world progression and win/lose.
- Consumes debounced button levels, collision and bonus pulses, and a 1 Hz tick enable, all in the `clk` domain.

---
 rtl/game_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_game_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Top-level play-session controller: sequences OFF/WLCM/CH/GAME/PA/WL and tracks lives,
// world, character and collision immunity for the obstacle generator.
module game_sequencer #(
    parameter int VIDAS_INI   = 3,
    parameter int WLCM_SEG    = 3,
    parameter int WL_SEG      = 5,
    parameter int INMUNE_SEG  = 2,
    parameter int MUNDO_FINAL = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_power,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       btn_sel,
    input  logic       colision,
    input  logic       bono_tomado,
    output logic [2:0] presente,
    output logic [1:0] W_or_L,
    output logic [1:0] mundo,
    output logic [1:0] vidas,
    output logic [1:0] personaje,
    output logic       inmune
);

    typedef enum logic [2:0] {
        S_OFF  = 3'd0,
        S_WLCM = 3'd1,
        S_CH   = 3'd2,
        S_GAME = 3'd3,
        S_WL   = 3'd4,
        S_PA   = 3'd5
    } state_t;

    localparam logic [3:0] WLCM_T  = 4'(WLCM_SEG);
    localparam logic [3:0] WL_T    = 4'(WL_SEG);
    localparam logic [3:0] INM_T   = 4'(INMUNE_SEG);
    localparam logic [1:0] VIDAS_L = 2'(VIDAS_INI);
    localparam logic [1:0] MUNDO_L = 2'(MUNDO_FINAL);

    state_t     state_reg, state_next;
    logic [1:0] w_or_l_reg, w_or_l_next;
    logic [1:0] mundo_reg, mundo_next;
    logic [1:0] vidas_reg, vidas_next;
    logic [1:0] personaje_reg, personaje_next;
    logic       inmune_reg, inmune_next;
    logic [3:0] timer_reg, timer_next;
    logic [3:0] inm_timer_reg, inm_timer_next;

    // Button order: 0=power, 1=start, 2=pause, 3=sel
    logic [3:0] btn_level;
    logic [3:0] btn_prev_reg;
    logic [3:0] btn_edge;

    assign btn_level = {btn_sel, btn_pause, btn_start, btn_power};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            always_ff @(posedge clk or posedge rst) begin
                if (rst) btn_prev_reg[gi] <= 1'b0;
                else     btn_prev_reg[gi] <= btn_level[gi];
            end
            assign btn_edge[gi] = btn_level[gi] & ~btn_prev_reg[gi];
        end
    endgenerate

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    logic [3:0] timer_tick;
    logic [3:0] inm_timer_tick;

    assign timer_tick     = tick_1hz ? sat_inc(timer_reg) : timer_reg;
    assign inm_timer_tick = tick_1hz ? sat_inc(inm_timer_reg) : inm_timer_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_OFF;
            w_or_l_reg    <= 2'b00;
            mundo_reg     <= 2'd0;
            vidas_reg     <= 2'd0;
            personaje_reg <= 2'd0;
            inmune_reg    <= 1'b0;
            timer_reg     <= 4'd0;
            inm_timer_reg <= 4'd0;
        end else begin
            state_reg     <= state_next;
            w_or_l_reg    <= w_or_l_next;
            mundo_reg     <= mundo_next;
            vidas_reg     <= vidas_next;
            personaje_reg <= personaje_next;
            inmune_reg    <= inmune_next;
            timer_reg     <= timer_next;
            inm_timer_reg <= inm_timer_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        w_or_l_next    = w_or_l_reg;
        mundo_next     = mundo_reg;
        vidas_next     = vidas_reg;
        personaje_next = personaje_reg;
        inmune_next    = inmune_reg;
        timer_next     = timer_reg;
        inm_timer_next = inm_timer_reg;

        case (state_reg)
            S_OFF: begin
                if (btn_edge[0]) begin
                    state_next = S_WLCM;
                    timer_next = 4'd0;
                end
            end
            S_WLCM: begin
                w_or_l_next = 2'b00;
                mundo_next  = 2'd0;
                timer_next  = timer_tick;
                if (btn_edge[1] || timer_tick >= WLCM_T) begin
                    state_next = S_CH;
                    timer_next = 4'd0;
                end
            end
            S_CH: begin
                if (btn_edge[3]) personaje_next = personaje_reg + 2'd1;
                if (btn_edge[1]) begin
                    state_next     = S_GAME;
                    vidas_next     = VIDAS_L;
                    mundo_next     = 2'd0;
                    w_or_l_next    = 2'b00;
                    inmune_next    = 1'b0;
                    inm_timer_next = 4'd0;
                    timer_next     = 4'd0;
                end
            end
            S_GAME: begin
                if (inmune_reg) begin
                    inm_timer_next = inm_timer_tick;
                    if (inm_timer_tick >= INM_T) inmune_next = 1'b0;
                end
                if (btn_edge[2]) state_next = S_PA;
                // Bonus outranks a same-clk collision; win/lose outranks pause
                if (bono_tomado) begin
                    if (mundo_reg < MUNDO_L) begin
                        mundo_next = mundo_reg + 2'd1;
                    end else begin
                        w_or_l_next = 2'b10;
                        state_next  = S_WL;
                        timer_next  = 4'd0;
                    end
                end else if (colision && !inmune_reg && vidas_reg != 2'd0) begin
                    vidas_next     = vidas_reg - 2'd1;
                    inmune_next    = 1'b1;
                    inm_timer_next = 4'd0;
                    if (vidas_reg == 2'd1) begin
                        w_or_l_next = 2'b01;
                        state_next  = S_WL;
                        timer_next  = 4'd0;
                    end
                end
            end
            S_PA: begin
                if (btn_edge[2]) state_next = S_GAME;
            end
            S_WL: begin
                timer_next = timer_tick;
                if (btn_edge[1] || timer_tick >= WL_T) begin
                    state_next     = S_WLCM;
                    w_or_l_next    = 2'b00;
                    mundo_next     = 2'd0;
                    vidas_next     = 2'd0;
                    inmune_next    = 1'b0;
                    inm_timer_next = 4'd0;
                    timer_next     = 4'd0;
                end
            end
            default: begin
                state_next = S_OFF;
            end
        endcase

        if (btn_edge[0] && state_reg != S_OFF) begin
            state_next     = S_OFF;
            w_or_l_next    = 2'b00;
            mundo_next     = 2'd0;
            vidas_next     = 2'd0;
            inmune_next    = 1'b0;
            timer_next     = 4'd0;
            inm_timer_next = 4'd0;
        end
    end

    assign presente  = state_reg;
    assign W_or_L    = w_or_l_reg;
    assign mundo     = mundo_reg;
    assign vidas     = vidas_reg;
    assign personaje = personaje_reg;
    assign inmune    = inmune_reg;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer: walks a full session, immunity,
// pause freeze, win/lose, same-clk priorities and asynchronous reset.
module tb_game_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz, btn_power, btn_start, btn_pause, btn_sel, colision, bono_tomado;
    logic [2:0] presente;
    logic [1:0] W_or_L, mundo, vidas, personaje;
    logic       inmune;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    game_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .tick_1hz    (tick_1hz),
        .btn_power   (btn_power),
        .btn_start   (btn_start),
        .btn_pause   (btn_pause),
        .btn_sel     (btn_sel),
        .colision    (colision),
        .bono_tomado (bono_tomado),
        .presente    (presente),
        .W_or_L      (W_or_L),
        .mundo       (mundo),
        .vidas       (vidas),
        .personaje   (personaje),
        .inmune      (inmune)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Press for one edge, then release for one edge so the next press is a fresh edge
    task automatic press(input int which);
        case (which)
            0: btn_power = 1'b1;
            1: btn_start = 1'b1;
            2: btn_pause = 1'b1;
            default: btn_sel = 1'b1;
        endcase
        step();
        btn_power = 1'b0; btn_start = 1'b0; btn_pause = 1'b0; btn_sel = 1'b0;
        step();
    endtask

    task automatic pulse_tick(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1hz = 1'b1;
            step();
            tick_1hz = 1'b0;
        end
    endtask

    task automatic pulse_ev(input logic c, input logic b);
        colision    = c;
        bono_tomado = b;
        step();
        colision    = 1'b0;
        bono_tomado = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        tick_1hz = 1'b0; btn_power = 1'b0; btn_start = 1'b0; btn_pause = 1'b0;
        btn_sel = 1'b0; colision = 1'b0; bono_tomado = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_presente", presente, 0);
        check_eq("rst_wl", W_or_L, 0);
        check_eq("rst_vidas", vidas, 0);
        check_eq("rst_pers", personaje, 0);
        rst = 1'b0;
        step();

        // Session start
        press(0);
        check_eq("power_to_wlcm", presente, 1);
        pulse_tick(2);
        check_eq("wlcm_2ticks", presente, 1);
        pulse_tick(1);
        check_eq("wlcm_3ticks_ch", presente, 2);
        press(3);
        press(3);
        check_eq("sel_x2", personaje, 2);
        press(1);
        check_eq("start_game", presente, 3);
        check_eq("start_vidas", vidas, 3);
        check_eq("start_mundo", mundo, 0);

        // Immunity
        pulse_ev(1'b1, 1'b0);
        check_eq("hit1_vidas", vidas, 2);
        check_eq("hit1_inmune", inmune, 1);
        pulse_ev(1'b1, 1'b0);
        check_eq("hit_immune_vidas", vidas, 2);
        pulse_tick(1);
        check_eq("inm_1tick", inmune, 1);
        pulse_tick(1);
        check_eq("inm_2ticks", inmune, 0);
        pulse_ev(1'b1, 1'b0);
        check_eq("hit2_vidas", vidas, 1);
        pulse_tick(2);

        // Loss
        pulse_ev(1'b1, 1'b0);
        check_eq("lose_vidas", vidas, 0);
        check_eq("lose_wl", W_or_L, 1);
        check_eq("lose_presente", presente, 4);
        pulse_tick(4);
        check_eq("wl_4ticks", presente, 4);
        check_eq("wl_hold_wl", W_or_L, 1);
        pulse_tick(1);
        check_eq("wl_5ticks", presente, 1);
        check_eq("wl_exit_wl", W_or_L, 0);
        check_eq("wl_exit_mundo", mundo, 0);

        // Win path with same-clk collision+bonus
        press(1);
        check_eq("wlcm_start_skip", presente, 2);
        press(1);
        check_eq("game2", presente, 3);
        pulse_ev(1'b1, 1'b1);
        check_eq("cb_mundo", mundo, 1);
        check_eq("cb_vidas", vidas, 3);
        pulse_ev(1'b0, 1'b1);
        check_eq("bono2_mundo", mundo, 2);
        pulse_ev(1'b0, 1'b1);
        check_eq("win_wl", W_or_L, 2);
        check_eq("win_presente", presente, 4);
        check_eq("win_mundo", mundo, 2);

        // Pause freezes immunity timer and ignores events
        press(1);
        check_eq("wl_start_early", presente, 1);
        press(1);
        press(1);
        check_eq("game3", presente, 3);
        pulse_ev(1'b1, 1'b0);
        pulse_tick(1);
        press(2);
        check_eq("pause_in", presente, 5);
        pulse_tick(2);
        pulse_ev(1'b1, 1'b0);
        pulse_ev(1'b0, 1'b1);
        check_eq("pa_presente", presente, 5);
        check_eq("pa_vidas", vidas, 2);
        check_eq("pa_mundo", mundo, 0);
        press(2);
        check_eq("pause_out", presente, 3);
        check_eq("resume_vidas", vidas, 2);
        check_eq("resume_inmune", inmune, 1);
        pulse_tick(1);
        check_eq("resume_inm_done", inmune, 0);

        // Power beats bonus in same clk
        btn_power = 1'b1;
        bono_tomado = 1'b1;
        step();
        btn_power = 1'b0;
        bono_tomado = 1'b0;
        check_eq("pwr_bono_presente", presente, 0);
        step();

        // Asynchronous reset mid-GAME
        press(0);
        press(1);
        press(1);
        pulse_ev(1'b0, 1'b1);
        check_eq("pre_rst_mundo", mundo, 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_presente", presente, 0);
        check_eq("arst_mundo", mundo, 0);
        check_eq("arst_vidas", vidas, 0);
        check_eq("arst_pers", personaje, 0);
        check_eq("arst_inmune", inmune, 0);
        check_eq("arst_wl", W_or_L, 0);
        step();
        rst = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
